// File: rtl/multi_timer_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer_sb_ctrl
// Brief    : Free-running system counter plus NUM_CH reloadable bus timers
//            with per-channel pending bits and a masked interrupt request.
// Revision : 1.0 - initial release
// ============================================================================
module multi_timer_sb_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        interrupt_request_o
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_NTIMES  = 2'd1,
        MODE_FOREVER = 2'd2
    } mode_e;

    localparam logic [1:0] c_REG_SYSCNT_LO = 2'd0;
    localparam logic [1:0] c_REG_SYSCNT_HI = 2'd1;
    localparam logic [1:0] c_REG_PENDING   = 2'd2;
    localparam logic [1:0] c_REG_ENABLE    = 2'd3;
    localparam logic [1:0] c_REG_DELAY_LO  = 2'd0;
    localparam logic [1:0] c_REG_DELAY_HI  = 2'd1;
    localparam logic [1:0] c_REG_MODE      = 2'd2;
    localparam logic [1:0] c_REG_REPEAT    = 2'd3;

    logic [11:0]       w_addr;
    logic [1:0]        w_reg;
    logic [3:0]        w_ch_idx;
    logic              w_glb_hit;
    logic              w_ch_hit;
    logic              w_wr;
    logic              w_rd;
    logic              w_unused_addr;

    logic [CNT_W-1:0]  syscnt_q;
    logic [31:0]       w_shadow_rd;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] enable_q;
    logic [NUM_CH-1:0] w_ev;
    logic [NUM_CH-1:0] w_w1c;
    logic              ready_q;
    logic [31:0]       rdata_q;
    logic [31:0]       w_rdata;
    logic [31:0]       w_ch_rdata [NUM_CH];

    assign w_addr        = addr_i[11:0];
    assign w_reg         = w_addr[3:2];
    assign w_ch_idx      = w_addr[7:4];
    assign w_unused_addr = ^addr_i[31:12];
    assign w_glb_hit     = (w_addr[11:4] == 8'h00) && (w_addr[1:0] == 2'b00);
    assign w_ch_hit      = (w_addr[11:8] == 4'h1) && (w_addr[1:0] == 2'b00)
                           && (32'(w_ch_idx) < NUM_CH);
    assign w_wr          = req_i && write_enable_i;
    assign w_rd          = req_i && !write_enable_i;

    assign w_w1c = (w_wr && w_glb_hit && (w_reg == c_REG_PENDING))
                   ? write_data_i[NUM_CH-1:0] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syscnt_q  <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            syscnt_q  <= syscnt_q + CNT_W'(1);
            // A new event outranks a software clear landing on the same edge.
            pending_q <= (pending_q & ~w_w1c) | w_ev;
            if (w_wr && w_glb_hit && (w_reg == c_REG_ENABLE)) begin
                enable_q <= write_data_i[NUM_CH-1:0];
            end
            ready_q   <= req_i;
            rdata_q   <= w_rd ? w_rdata : '0;
        end
    end

    if (CNT_W > 32) begin : g_shadow
        logic [CNT_W-33:0] shadow_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_q <= '0;
            end else if (w_rd && w_glb_hit && (w_reg == c_REG_SYSCNT_LO)) begin
                shadow_q <= syscnt_q[CNT_W-1:32];
            end
        end
        assign w_shadow_rd = 32'(shadow_q);
    end else begin : g_no_shadow
        assign w_shadow_rd = '0;
    end

    always_comb begin
        w_rdata = '0;
        if (w_glb_hit) begin
            unique case (w_reg)
                c_REG_SYSCNT_LO: w_rdata = syscnt_q[31:0];
                c_REG_SYSCNT_HI: w_rdata = w_shadow_rd;
                c_REG_PENDING:   w_rdata = 32'(pending_q);
                c_REG_ENABLE:    w_rdata = 32'(enable_q);
                default:         w_rdata = '0;
            endcase
        end else if (w_ch_hit) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (w_ch_idx == 4'(n)) begin
                    w_rdata = w_ch_rdata[n];
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [31:0]      dly_lo_q;
        logic [31:0]      dly_hi_rd;
        logic [CNT_W-1:0] dly;
        logic [CNT_W-1:0] reload;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [31:0]      rep_q;
        logic [31:0]      rep_d;
        mode_e            mode_q;
        mode_e            mode_d;
        mode_e            mode_wr;
        logic             sel;
        logic             stall;
        logic             active;
        logic [31:0]      rd;

        assign sel = w_wr && w_ch_hit && (w_ch_idx == 4'(n));

        if (CNT_W > 32) begin : g_dhi
            logic [CNT_W-33:0] dly_hi_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    dly_hi_q <= '0;
                end else if (sel && (w_reg == c_REG_DELAY_HI)) begin
                    dly_hi_q <= write_data_i[CNT_W-33:0];
                end
            end
            assign dly       = {dly_hi_q, dly_lo_q};
            assign dly_hi_rd = 32'(dly_hi_q);
        end else begin : g_no_dhi
            assign dly       = dly_lo_q;
            assign dly_hi_rd = '0;
        end

        // NTIMES with nothing left to do never fires; it just drops to OFF.
        assign stall    = (mode_q == MODE_NTIMES) && (rep_q == 32'd0);
        assign active   = (mode_q != MODE_OFF) && !stall;
        assign w_ev[n]  = active && (cnt_q == CNT_W'(1));
        assign reload   = (dly == '0) ? CNT_W'(1) : dly;

        always_comb begin
            unique case (write_data_i[1:0])
                2'd1:    mode_wr = MODE_NTIMES;
                2'd2:    mode_wr = MODE_FOREVER;
                default: mode_wr = MODE_OFF;
            endcase

            rep_d = rep_q;
            if (sel && (w_reg == c_REG_REPEAT)) begin
                rep_d = write_data_i;
            end else if (w_ev[n] && (mode_q == MODE_NTIMES)) begin
                rep_d = rep_q - 32'd1;
            end

            mode_d = mode_q;
            if (sel && (w_reg == c_REG_MODE)) begin
                mode_d = mode_wr;
            end else if ((mode_q == MODE_NTIMES) && (w_ev[n] || stall)
                         && (rep_d == 32'd0)) begin
                mode_d = MODE_OFF;
            end

            cnt_d = cnt_q;
            if (sel && (w_reg == c_REG_MODE)) begin
                if (mode_wr != MODE_OFF) begin
                    cnt_d = reload;
                end
            end else if (w_ev[n]) begin
                cnt_d = reload;
            end else if (active) begin
                cnt_d = cnt_q - CNT_W'(1);
            end

            unique case (w_reg)
                c_REG_DELAY_LO: rd = dly_lo_q;
                c_REG_DELAY_HI: rd = dly_hi_rd;
                c_REG_MODE:     rd = {30'd0, mode_q};
                c_REG_REPEAT:   rd = rep_q;
                default:        rd = '0;
            endcase
        end

        assign w_ch_rdata[n] = rd;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dly_lo_q <= '0;
                rep_q    <= '0;
                mode_q   <= MODE_OFF;
                cnt_q    <= '0;
            end else begin
                if (sel && (w_reg == c_REG_DELAY_LO)) begin
                    dly_lo_q <= write_data_i;
                end
                rep_q  <= rep_d;
                mode_q <= mode_d;
                cnt_q  <= cnt_d;
            end
        end
    end

    assign ready_o             = ready_q;
    assign read_data_o         = rdata_q;
    assign interrupt_request_o = |(pending_q & enable_q);

endmodule
`default_nettype wire

// File: tb/tb_multi_timer_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_timer_sb_ctrl
// Brief    : Directed and randomized bench for multi_timer_sb_ctrl against an
//            event-schedule model (events expected at arm + k*max(DELAY,1)).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_timer_sb_ctrl;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 64;
    localparam logic [31:0] A_LO   = 32'h000;
    localparam logic [31:0] A_HI   = 32'h004;
    localparam logic [31:0] A_PEND = 32'h008;
    localparam logic [31:0] A_EN   = 32'h00C;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    multi_timer_sb_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .req_i               (req),
        .write_enable_i      (we),
        .addr_i              (addr),
        .write_data_i        (wdata),
        .read_data_o         (rdata),
        .ready_o             (ready),
        .interrupt_request_o (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    int   exp_ev[$];
    logic pend_m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ch_a(input int ch, input int off);
        return 32'(32'h100 + 16 * ch + off);
    endfunction

    function automatic logic is_ev(input int c);
        foreach (exp_ev[i]) if (exp_ev[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        chk("ready_ack", ready, 1);
        d = rdata;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int t);
        for (int i = 0; i < 1000 && cyc < t; i++) begin @(posedge clk); #1; end
    endtask

    task automatic arm(input int ch, input logic [31:0] d, input logic [31:0] r,
                       input logic [31:0] md, output int e0);
        bus_write(ch_a(ch, 0), d);
        bus_write(ch_a(ch, 4), 32'd0);
        bus_write(ch_a(ch, 12), r);
        bus_write(ch_a(ch, 8), md);
        e0 = cyc;
    endtask

    // Cycle-by-cycle: clears each observed pending bit by W1C and compares irq
    // with the model; an optional extra write is placed at edge xw_cyc.
    task automatic watch(input int ch, input int ncyc, input logic en, input int xw_cyc,
                         input logic [31:0] xw_addr, input logic [31:0] xw_data);
        logic clr;
        for (int i = 0; i < ncyc; i++) begin
            clr = 1'b0;
            if (cyc + 1 == xw_cyc) begin
                req = 1'b1; we = 1'b1; addr = xw_addr; wdata = xw_data;
            end else if (pend_m) begin
                req = 1'b1; we = 1'b1; addr = A_PEND; wdata = 32'(1) << ch;
                clr = 1'b1;
            end else begin
                req = 1'b0; we = 1'b0;
            end
            @(posedge clk); #1;
            pend_m = (pend_m & ~clr) | is_ev(cyc);
            chk($sformatf("irq_ch%0d_t%0d", ch, i), irq, pend_m & en);
        end
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        logic [31:0] v1, v2, v;
        logic [63:0] exp64;
        int e0, ef, ec, ch, d, eff, r, md, win;
        logic [31:0] zaddr [8];

        // ---------------- reset and system counter ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        bus_read(A_LO, v1);
        idle(9);
        bus_read(A_LO, v2);
        chk("syscnt_delta10", v2 - v1, 10);
        idle(1);
        chk("ready_drop", ready, 0);
        chk("rdata_idle_zero", rdata, 0);

        zaddr = '{A_HI, A_PEND, A_EN, 32'h100, 32'h104, 32'h108, 32'h13C, 32'h134};
        foreach (zaddr[i]) read_chk($sformatf("rst_reg_%0h", zaddr[i]), zaddr[i], 0);

        v = $urandom;
        bus_write(ch_a(3, 4), v);
        read_chk("delay_hi_rw", ch_a(3, 4), v);
        bus_write(ch_a(3, 4), 0);
        bus_write(ch_a(1, 8), 3);
        read_chk("mode3_is_off", ch_a(1, 8), 0);

        // ---------------- NTIMES ch0, delay 5, repeat 3 ----------------
        bus_write(A_EN, 1);
        arm(0, 5, 3, 1, e0);
        exp_ev = '{e0 + 5, e0 + 10, e0 + 15};
        pend_m = 1'b0;
        watch(0, 45, 1'b1, -1, 0, 0);
        read_chk("nt_mode_off", ch_a(0, 8), 0);
        read_chk("nt_repeat_zero", ch_a(0, 12), 0);
        read_chk("nt_pending_clear", A_PEND, 0);

        // NTIMES armed with REPEAT=0 must not fire even with delay 1
        arm(0, 1, 0, 1, e0);
        exp_ev = {};
        pend_m = 1'b0;
        watch(0, 8, 1'b1, -1, 0, 0);
        read_chk("nt0_mode_off", ch_a(0, 8), 0);

        // ---------------- FOREVER ch2 with mid-run delay change ----------------
        bus_write(A_EN, 4);
        arm(2, 4, 9, 2, e0);
        exp_ev = '{e0 + 4, e0 + 11, e0 + 18};
        pend_m = 1'b0;
        watch(2, 22, 1'b1, e0 + 2, ch_a(2, 0), 7);
        bus_write(ch_a(2, 8), 0);
        exp_ev = {};
        watch(2, 10, 1'b1, -1, 0, 0);
        read_chk("fe_repeat_kept", ch_a(2, 12), 9);
        read_chk("fe_delay_new", ch_a(2, 0), 7);

        // ---------------- set-vs-clear collision on ch1 ----------------
        bus_write(A_EN, 2);
        arm(1, 4, 0, 2, e0);
        wait_until(e0 + 3);
        bus_write(A_PEND, 2);
        chk("coll_irq_stays", irq, 1);
        read_chk("coll_pend_set", A_PEND, 2);
        bus_write(A_PEND, 2);
        chk("w1c_irq_falls", irq, 0);
        bus_write(A_EN, 0);
        wait_until(e0 + 9);
        chk("masked_irq_low", irq, 0);
        read_chk("masked_pend_set", A_PEND, 2);
        bus_write(ch_a(1, 8), 0);
        bus_write(A_PEND, 2);
        idle(6);
        read_chk("stop_no_event", A_PEND, 0);

        // ---------------- randomized channels vs event schedule ----------------
        for (int it = 0; it < 5; it++) begin
            ch  = int'($urandom_range(0, NUM_CH - 1));
            d   = int'($urandom_range(0, 9));
            eff = (d == 0) ? 1 : d;
            r   = int'($urandom_range(1, 4));
            md  = int'($urandom_range(1, 2));
            win = (r + 2) * eff + 4;
            bus_write(A_EN, 32'(1) << ch);
            arm(ch, 32'(d), 32'(r), 32'(md), e0);
            exp_ev = {};
            for (int k = 1; k * eff <= win; k++)
                if (md == 2 || k <= r) exp_ev.push_back(e0 + k * eff);
            pend_m = 1'b0;
            watch(ch, win, 1'b1, -1, 0, 0);
            if (md == 1) begin
                read_chk($sformatf("rnd%0d_mode", it), ch_a(ch, 8), 0);
                read_chk($sformatf("rnd%0d_repeat", it), ch_a(ch, 12), 0);
            end else begin
                read_chk($sformatf("rnd%0d_mode", it), ch_a(ch, 8), 2);
                read_chk($sformatf("rnd%0d_repeat", it), ch_a(ch, 12), 32'(r));
                bus_write(ch_a(ch, 8), 0);
            end
            bus_write(A_PEND, 32'hF);
            idle(12);
            read_chk($sformatf("rnd%0d_quiet", it), A_PEND, 0);
        end

        // ---------------- 64-bit snapshot across the 32-bit carry ----------------
        force dut.syscnt_q = 64'h0000_0000_FFFF_FFFC;
        ef = cyc;
        #1 release dut.syscnt_q;
        read_chk("snap_lo_pre", A_LO, 32'hFFFF_FFFC);
        idle(5);
        read_chk("snap_hi_old", A_HI, 0);
        bus_read(A_LO, v);
        ec = cyc;
        exp64 = 64'h0000_0000_FFFF_FFFC + 64'(ec - ef - 1);
        chk("snap_lo_post", v, exp64[31:0]);
        read_chk("snap_hi_new", A_HI, exp64[63:32]);

        bus_write(A_EN, 5);
        bus_write(32'h1F0, 32'hFFFF_FFFF);
        read_chk("unmapped_rd", 32'h1F0, 0);
        read_chk("unmapped_wr_ignored", A_EN, 5);
        read_chk("upper_addr_ignored", 32'hABCD_000C, 5);
        bus_write(A_EN, 0);

        // ---------------- asynchronous reset mid-run ----------------
        bus_write(A_EN, 1);
        arm(0, 6, 4, 1, e0);
        wait_until(e0 + 6);
        chk("pre_rst_irq", irq, 1);
        bus_read(A_LO, v);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", ready, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_irq", irq, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bus_write(A_EN, 1);
        exp_ev = {};
        pend_m = 1'b0;
        watch(0, 30, 1'b1, -1, 0, 0);
        read_chk("post_rst_mode", ch_a(0, 8), 0);
        read_chk("post_rst_repeat", ch_a(0, 12), 0);
        read_chk("post_rst_delay", ch_a(0, 0), 0);
        read_chk("post_rst_pend", A_PEND, 0);
        bus_read(A_LO, v);
        chk("post_rst_syscnt_small", 64'(v < 32'd50), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
